seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
Parametrised multiplexed hex display driver for NUM_DIGITS common-anode or common-cathode 7-segment digits with decimal points. It time-multiplexes one digit per scan slot and snapshots the input word once per frame, so a frame never mixes old and new data. Optional leading-zero blanking and a ghosting guard interval are included. It sits between any data-producing block and the board's digit/segment pins, and replaces the fixed 2-digit scanner.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8); digit 0 is the least-significant nibble and the rightmost digit.
DIV, 50000, clk cycles per digit slot (>= 2).
GUARD, 16, cycles at the start of each slot with all digits disabled (0 <= GUARD < DIV).
DIG_ACTIVE_LOW, 1, 1 means the digit enables are active-low.
SEG_ACTIVE_LOW, 1, 1 means the segments and dp are active-low.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
data  in  4*NUM_DIGITS  hex value; nibble i drives digit i.
dp  in  NUM_DIGITS  decimal point per digit; 1 means lit.
blank_lz  in  1  1 enables leading-zero blanking.
digit  out  NUM_DIGITS  digit enables, one-hot per the configured polarity.
segments  out  8  {dp,g,f,e,d,c,b,a}, per the configured polarity.
frame  out  1  single-cycle pulse when a new snapshot is taken.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - cnt=0, idx=0, shadow data/dp/blank_lz=0.
  - digit = all inactive; segments = all off; frame=0.
  - Reset asserted mid-scan forces these values immediately.
- Prescaler: cnt counts 0..DIV-1 and wraps. tick = (cnt==DIV-1).
- Scan index: on tick, idx increments; it wraps from NUM_DIGITS-1 to 0.
- Snapshot: on tick with idx==NUM_DIGITS-1, the next cycle has shadow<=data/dp/blank_lz and frame=1.
  - The first frame after reset therefore shows shadow=0.
  - Inputs changed mid-frame have no visible effect until the next snapshot.
- Decode (active-high values before polarity inversion): 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71. Bit7 = shadow dp[idx].
- Leading-zero blanking: when shadow blank_lz=1, digit i (i>0) is blank if all shadow nibbles i..NUM_DIGITS-1 are 0.
  - A blank digit has segments a..g off; its dp bit is still driven from dp[i].
  - Digit 0 is never blanked.
- Guard: while cnt < GUARD, all digits are inactive and all segments off.
- Output registers: digit, segments and frame are registered.
  - Outputs at cycle k reflect cnt/idx/shadow at cycle k-1 (1-cycle latency).
  - Exactly one digit is active outside guard; none is active during guard.
- Polarity: inversion is applied at the output register only. Internal logic is polarity-independent.
- NUM_DIGITS=1: idx stays 0, and a snapshot occurs on every tick.

Test Plan:
All cases use NUM_DIGITS=4, DIV=4, GUARD=1, active-low, unless stated otherwise.

1. Reset: hold rst_n=0 → digit=4'hF, segments=8'hFF, frame=0. Assert rst_n=0 mid-slot → outputs return to these values within the same cycle.
2. Scan order: data=16'h12AF, dp=0, blank_lz=0, run 2 frames. After the first frame pulse, the required sequence per slot is:
   - 1 guard cycle with digit=F, segments=FF;
   - 3 cycles of digit0: digit=E, segments=8E;
   - digit1: digit=D, segments=88;
   - digit2: digit=B, segments=A4;
   - digit3: digit=7, segments=F9.
   frame pulses exactly once every 16 cycles.
3. Snapshot isolation: change data from 16'h1111 to 16'h2222 during the digit1 slot → the remaining slots show F9 until the next frame pulse, then A4.
4. Blanking: data=16'h0050, blank_lz=1 → digit3/digit2 segments=FF, digit1 92, digit0 C0. With data=0, only digit0 shows C0.
5. dp on a blanked digit: data=16'h0005, dp=4'b0100, blank_lz=1 → digit2 segments=7F, digit0 92.
6. Polarity: DIG_ACTIVE_LOW=0, SEG_ACTIVE_LOW=0, data=16'h0000 → digit0 slot shows digit=4'b0001, segments=3F; guard cycles show digit=0, segments=00.

Source files
------------

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed hex 7-segment display driver.
// One digit per scan slot, input snapshotted once per frame.
module seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int DIV            = 50000,
  parameter int GUARD          = 16,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   digit,
  output logic [7:0]              segments,
  output logic                    frame
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [NUM_DIGITS-1:0] DIG_OFF =
    (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [7:0] SEG_OFF =
    (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] sh_data;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic                    sh_blz;

  logic tick;
  logic last;
  logic snap;
  logic in_guard;

  logic [NUM_DIGITS-1:0] lz;
  logic [NUM_DIGITS-1:0] dig_hi;
  logic [7:0]            seg_hi;
  logic [3:0]            nib;
  logic                  dp_bit;
  logic                  blank_sel;

  assign tick = (cnt == CW'(DIV - 1));
  assign last = (idx == IW'(NUM_DIGITS - 1));
  assign snap = tick & last;

  generate
    if (GUARD > 0) begin : g_guard
      assign in_guard = (cnt < CW'(GUARD));
    end else begin : g_no_guard
      assign in_guard = 1'b0;
    end
  endgenerate

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Slot prescaler: wraps every DIV cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Scan index advances once per slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (tick) begin
      if (last) idx <= '0;
      else      idx <= idx + 1'b1;
    end
  end

  // Frame snapshot so one frame never mixes old and new data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_data <= '0;
      sh_dp   <= '0;
      sh_blz  <= 1'b0;
    end else if (snap) begin
      sh_data <= data;
      sh_dp   <= dp;
      sh_blz  <= blank_lz;
    end
  end

  // lz[i]: all shadow nibbles from i up to the top are zero
  always_comb begin
    logic run;
    run = 1'b1;
    lz  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run   = run & (sh_data[4*i +: 4] == 4'h0);
      lz[i] = run;
    end
  end

  // Select current digit and build active-high drive values
  always_comb begin
    nib       = 4'h0;
    dp_bit    = 1'b0;
    blank_sel = 1'b0;
    dig_hi    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib       = sh_data[4*i +: 4];
        dp_bit    = sh_dp[i];
        blank_sel = (i != 0) && lz[i];
        dig_hi[i] = 1'b1;
      end
    end
    seg_hi = {dp_bit, (sh_blz && blank_sel) ? 7'h00 : hex7(nib)};
    if (in_guard) begin
      dig_hi = '0;
      seg_hi = 8'h00;
    end
  end

  // Registered pin drivers; polarity applied only here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit    <= DIG_OFF;
      segments <= SEG_OFF;
      frame    <= 1'b0;
    end else begin
      digit    <= dig_hi ^ DIG_OFF;
      segments <= seg_hi ^ SEG_OFF;
      frame    <= snap;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard bench for seg_scan_driver.
// Two instances: active-low pins and active-high pins.
module tb_seg_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] data, data_p;
  logic [3:0]  dp, dp_p;
  logic        blz, blz_p;
  logic [3:0]  digit, digit_p;
  logic [7:0]  seg, seg_p;
  logic        frame, frame_p;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic [3:0] dig;
    logic [7:0] seg;
    logic       frm;
  } exp_t;

  exp_t sbq[$];

  seg_scan_driver #(
    .NUM_DIGITS(4), .DIV(4), .GUARD(1),
    .DIG_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .dp(dp),
    .blank_lz(blz), .digit(digit), .segments(seg),
    .frame(frame)
  );

  seg_scan_driver #(
    .NUM_DIGITS(4), .DIV(4), .GUARD(1),
    .DIG_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)
  ) dut_p (
    .clk(clk), .rst_n(rst_n), .data(data_p), .dp(dp_p),
    .blank_lz(blz_p), .digit(digit_p), .segments(seg_p),
    .frame(frame_p)
  );

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;
      4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;
      4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;
      4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;
      4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // 16 cycles after a frame pulse: per slot one guard + 3 lit cycles
  task automatic push_frame(input logic [15:0] d, input logic [3:0] p,
                            input logic b, input bit alow);
    exp_t e;
    int slot, pos;
    logic [3:0]  dh;
    logic [7:0]  sh;
    logic [15:0] rest;
    for (int k = 1; k <= 16; k++) begin
      slot = (k - 1) / 4;
      pos  = (k - 1) % 4;
      if (pos == 0) begin
        dh = 4'h0;
        sh = 8'h00;
      end else begin
        dh   = 4'(1 << slot);
        rest = d >> (4 * slot);
        sh   = {p[slot],
                (b && slot > 0 && rest == 16'h0) ? 7'h00 : hex7(rest[3:0])};
      end
      e.dig = alow ? ~dh : dh;
      e.seg = alow ? ~sh : sh;
      e.frm = (k == 16);
      sbq.push_back(e);
    end
  endtask

  task automatic drain(input bit sel, input int chg_at,
                       input logic [15:0] chg_d);
    exp_t e;
    int k;
    logic [3:0] od;
    logic [7:0] os;
    logic       of;
    k = 0;
    while (sbq.size() > 0) begin
      @(negedge clk);
      e = sbq.pop_front();
      k++;
      od = sel ? digit_p : digit;
      os = sel ? seg_p   : seg;
      of = sel ? frame_p : frame;
      checks++;
      if ({od, os, of} !== {e.dig, e.seg, e.frm}) begin
        fails++;
        $display("FAIL scan inst%0d cyc%0d: digit=%h seg=%h frame=%b, required digit=%h seg=%h frame=%b",
                 sel, k, od, os, of, e.dig, e.seg, e.frm);
      end
      if (k == chg_at) data = chg_d;
    end
  endtask

  task automatic wait_frame(input bit sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if ((sel ? frame_p : frame) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic sync_frame(input bit sel, input string name);
    bit ok;
    wait_frame(sel, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: no frame pulse within 64 cycles, required one", name);
      sbq.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    data = 16'h0; dp = 4'h0; blz = 1'b0;
    data_p = 16'h0; dp_p = 4'h0; blz_p = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (digit !== 4'hF) begin
      fails++; $display("FAIL reset digit: got %h, required F", digit);
    end
    checks++;
    if (seg !== 8'hFF) begin
      fails++; $display("FAIL reset seg: got %h, required FF", seg);
    end
    checks++;
    if (frame !== 1'b0) begin
      fails++; $display("FAIL reset frame: got %b, required 0", frame);
    end
    checks++;
    if ({digit_p, seg_p} !== 12'h000) begin
      fails++; $display("FAIL reset pol: got %h %h, required 0 00", digit_p, seg_p);
    end
    data  = 16'h12AF;
    rst_n = 1'b1;
    push_frame(16'h0, 4'h0, 1'b0, 1'b1);
    drain(1'b0, -1, 16'h0);
  endtask

  task automatic test_scan();
    data = 16'h12AF; dp = 4'h0; blz = 1'b0;
    push_frame(16'h12AF, 4'h0, 1'b0, 1'b1);
    push_frame(16'h12AF, 4'h0, 1'b0, 1'b1);
    sync_frame(1'b0, "scan");
    drain(1'b0, -1, 16'h0);
  endtask

  task automatic test_snapshot();
    data = 16'h1111;
    push_frame(16'h1111, 4'h0, 1'b0, 1'b1);
    push_frame(16'h2222, 4'h0, 1'b0, 1'b1);
    sync_frame(1'b0, "snapshot");
    drain(1'b0, 6, 16'h2222);
  endtask

  task automatic test_blank();
    data = 16'h0050; dp = 4'h0; blz = 1'b1;
    push_frame(16'h0050, 4'h0, 1'b1, 1'b1);
    sync_frame(1'b0, "blank");
    drain(1'b0, -1, 16'h0);
    data = 16'h0000;
    push_frame(16'h0000, 4'h0, 1'b1, 1'b1);
    sync_frame(1'b0, "blank_zero");
    drain(1'b0, -1, 16'h0);
  endtask

  task automatic test_dp_blank();
    data = 16'h0005; dp = 4'b0100; blz = 1'b1;
    push_frame(16'h0005, 4'b0100, 1'b1, 1'b1);
    sync_frame(1'b0, "dp_blank");
    drain(1'b0, -1, 16'h0);
  endtask

  task automatic test_polarity();
    data_p = 16'h0000; dp_p = 4'h0; blz_p = 1'b0;
    push_frame(16'h0000, 4'h0, 1'b0, 1'b0);
    sync_frame(1'b1, "polarity");
    drain(1'b1, -1, 16'h0);
  endtask

  task automatic test_reset_mid();
    data = 16'h12AF; dp = 4'h0; blz = 1'b0;
    sync_frame(1'b0, "reset_mid");
    repeat (2) @(negedge clk);
    checks++;
    if (digit !== 4'hE) begin
      fails++; $display("FAIL mid pre digit: got %h, required E", digit);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({digit, seg, frame} !== {4'hF, 8'hFF, 1'b0}) begin
      fails++;
      $display("FAIL mid reset: got %h %h %b, required F FF 0", digit, seg, frame);
    end
    checks++;
    if ({digit_p, seg_p} !== 12'h000) begin
      fails++; $display("FAIL mid reset pol: got %h %h, required 0 00", digit_p, seg_p);
    end
    @(negedge clk);
    rst_n = 1'b1;
    push_frame(16'h0, 4'h0, 1'b0, 1'b1);
    drain(1'b0, -1, 16'h0);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_snapshot();
    test_blank();
    test_dp_blank();
    test_polarity();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
